// File: rtl/coin_mech.sv
// Coin acceptor/dispenser mechanism: timed detect pulses, return decode, tube levels.
// Optional COIN_MECH_STATS_EN adds coins_in/coins_out event counters.
module coin_mech #(
    parameter int DETECT_W   = 8,
    parameter int GAP_W      = 40,
    parameter int MIN_RET_W  = 4,
    parameter int CNT_W      = 6,
    parameter int TUBE_DEPTH = 63,
    parameter int INIT_LEVEL = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    output logic             coin_ready,
    output logic             coin_reject,
    output logic             detect_5,
    output logic             detect_10,
    output logic             detect_25,
    input  logic             return_5,
    input  logic             return_10,
    input  logic             return_25,
    input  logic             refill,
    output logic             empty_5,
    output logic             empty_10,
    output logic             empty_25,
    output logic [CNT_W-1:0] level_5,
    output logic [CNT_W-1:0] level_10,
    output logic [CNT_W-1:0] level_25,
    output logic             err_underflow
`ifdef COIN_MECH_STATS_EN
    ,
    output logic [15:0]      coins_in,
    output logic [15:0]      coins_out
`endif
);

    localparam int MAXW = (DETECT_W > GAP_W) ? DETECT_W : GAP_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int WW   = $clog2(MIN_RET_W + 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       ctype;
    logic [2:0]       inc_req;
    logic [2:0]       inc_ok;
    logic [2:0]       dec_req;
    logic [2:0]       ret;
    logic [2:0]       ret_q;
    logic [WW-1:0]    width [3];
    logic [CNT_W-1:0] lvl [3];

    assign coin_ready = (state == IDLE);
    assign ret        = {return_25, return_10, return_5};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ctype       <= 2'd0;
            coin_reject <= 1'b0;
            detect_5    <= 1'b0;
            detect_10   <= 1'b0;
            detect_25   <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (coin_valid) begin
                        if (coin_type == 2'd3) begin
                            coin_reject <= 1'b1;
                        end else begin
                            state     <= PULSE;
                            cnt       <= '0;
                            ctype     <= coin_type;
                            detect_5  <= (coin_type == 2'd0);
                            detect_10 <= (coin_type == 2'd1);
                            detect_25 <= (coin_type == 2'd2);
                        end
                    end
                end
                PULSE: begin
                    if (cnt == CW'(DETECT_W - 1)) begin
                        state     <= GAP;
                        cnt       <= '0;
                        detect_5  <= 1'b0;
                        detect_10 <= 1'b0;
                        detect_25 <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CW'(GAP_W - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        inc_req = 3'b000;
        inc_ok  = 3'b000;
        dec_req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            inc_req[i] = (state == PULSE) && (cnt == CW'(DETECT_W - 1))
                         && (ctype == 2'(i));
            inc_ok[i]  = inc_req[i] && (lvl[i] < CNT_W'(TUBE_DEPTH));
            dec_req[i] = ret_q[i] && !ret[i] && (width[i] >= WW'(MIN_RET_W));
        end
    end

    // width 0 means "not armed": a line high across reset never qualifies
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q <= 3'b111;
            for (int i = 0; i < 3; i++) width[i] <= '0;
        end else begin
            ret_q <= ret;
            for (int i = 0; i < 3; i++) begin
                if (ret[i] && !ret_q[i])
                    width[i] <= WW'(1);
                else if (ret[i] && width[i] != '0 && width[i] < WW'(MIN_RET_W))
                    width[i] <= width[i] + 1'b1;
                else if (!ret[i])
                    width[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underflow <= 1'b0;
            for (int i = 0; i < 3; i++) lvl[i] <= CNT_W'(INIT_LEVEL);
        end else if (refill) begin
            for (int i = 0; i < 3; i++) lvl[i] <= CNT_W'(INIT_LEVEL);
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inc_ok[i] && dec_req[i])
                    lvl[i] <= lvl[i];
                else if (inc_ok[i])
                    lvl[i] <= lvl[i] + 1'b1;
                else if (dec_req[i]) begin
                    if (lvl[i] != '0)
                        lvl[i] <= lvl[i] - 1'b1;
                    else
                        err_underflow <= 1'b1;
                end
            end
        end
    end

`ifdef COIN_MECH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            coins_in  <= 16'd0;
            coins_out <= 16'd0;
        end else begin
            if (|inc_req)
                coins_in <= coins_in + 16'd1;
            if ((dec_req[0] && lvl[0] != '0) || (dec_req[1] && lvl[1] != '0)
                || (dec_req[2] && lvl[2] != '0))
                coins_out <= coins_out + 16'd1;
        end
    end
`endif

    assign level_5  = lvl[0];
    assign level_10 = lvl[1];
    assign level_25 = lvl[2];
    assign empty_5  = (lvl[0] == '0);
    assign empty_10 = (lvl[1] == '0);
    assign empty_25 = (lvl[2] == '0);

endmodule

// File: tb/tb_coin_mech.sv
// Randomized + directed bench for coin_mech against an event-time reference model.
module tb_coin_mech;

    localparam int DW   = 8;
    localparam int GW   = 40;
    localparam int MINR = 4;
    localparam int DEP  = 63;
    localparam int INIT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       coin_ready, coin_reject;
    logic       detect_5, detect_10, detect_25;
    logic       return_5 = 1'b0, return_10 = 1'b0, return_25 = 1'b0;
    logic       refill = 1'b0;
    logic       empty_5, empty_10, empty_25;
    logic [5:0] level_5, level_10, level_25;
    logic       err_underflow;

    coin_mech dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_ready(coin_ready), .coin_reject(coin_reject),
        .detect_5(detect_5), .detect_10(detect_10), .detect_25(detect_25),
        .return_5(return_5), .return_10(return_10), .return_25(return_25),
        .refill(refill),
        .empty_5(empty_5), .empty_10(empty_10), .empty_25(empty_25),
        .level_5(level_5), .level_10(level_10), .level_25(level_25),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    bit started = 0;

    // Model: time since last accepted coin decides detect/ready; tubes are ints
    int e = 0;
    int ea = -1000000;
    int mtyp = 0;
    int lv[3];
    int mrun[3];
    bit mprev[3];
    bit merr, mrej;

    always @(posedge clk) begin
        bit line[3];
        bit rdy_b, vf, inc_here;
        line[0] = return_5;
        line[1] = return_10;
        line[2] = return_25;
        if (reset) begin
            e++;
            ea = -1000000;
            merr = 0;
            mrej = 0;
            for (int i = 0; i < 3; i++) begin
                lv[i] = INIT;
                mrun[i] = 0;
                mprev[i] = 1;
            end
        end else begin
            rdy_b = (e - ea) >= DW + GW;
            e++;
            inc_here = (e - ea) == DW;
            for (int i = 0; i < 3; i++) begin
                vf = 0;
                if (line[i] && !mprev[i]) mrun[i] = 1;
                else if (line[i] && mrun[i] > 0) mrun[i]++;
                else if (!line[i] && mprev[i]) begin
                    vf = mrun[i] >= MINR;
                    mrun[i] = 0;
                end
                mprev[i] = line[i];
                if (!refill) begin
                    if (inc_here && mtyp == i && lv[i] < DEP) begin
                        if (!vf) lv[i]++;
                    end else if (vf) begin
                        if (lv[i] > 0) lv[i]--;
                        else merr = 1;
                    end
                end
            end
            if (refill)
                for (int i = 0; i < 3; i++) lv[i] = INIT;
            mrej = rdy_b && coin_valid && coin_type == 2'd3;
            if (rdy_b && coin_valid && coin_type != 2'd3) begin
                ea = e;
                mtyp = coin_type;
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            bit xr, xd5, xd10, xd25, ok;
            xr   = (e - ea) >= DW + GW;
            xd5  = (e - ea) < DW && mtyp == 0;
            xd10 = (e - ea) < DW && mtyp == 1;
            xd25 = (e - ea) < DW && mtyp == 2;
            ok = coin_ready === xr && coin_reject === mrej
              && detect_5 === xd5 && detect_10 === xd10 && detect_25 === xd25
              && int'(level_5) == lv[0] && int'(level_10) == lv[1]
              && int'(level_25) == lv[2]
              && empty_5 === (lv[0] == 0) && empty_10 === (lv[1] == 0)
              && empty_25 === (lv[2] == 0) && err_underflow === merr;
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL model t=%0t got rdy=%b rej=%b det=%b%b%b lv=%0d/%0d/%0d err=%b want rdy=%b rej=%b det=%b%b%b lv=%0d/%0d/%0d err=%b",
                    $time, coin_ready, coin_reject, detect_5, detect_10, detect_25,
                    level_5, level_10, level_25, err_underflow,
                    xr, mrej, xd5, xd10, xd25, lv[0], lv[1], lv[2], merr);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic int det(input int t);
        case (t)
            0: return int'(detect_5);
            1: return int'(detect_10);
            default: return int'(detect_25);
        endcase
    endfunction

    task automatic insert(input int t, output int dcnt, output int n);
        coin_valid = 1'b1;
        coin_type = 2'(t);
        step();
        coin_valid = 1'b0;
        dcnt = 0;
        n = 0;
        while (!coin_ready && n < 200) begin
            dcnt += det(t);
            step();
            n++;
        end
    endtask

    task automatic ret_pulse(input int i, input int w);
        case (i)
            0: return_5 = 1'b1;
            1: return_10 = 1'b1;
            default: return_25 = 1'b1;
        endcase
        step(w);
        return_5 = 1'b0;
        return_10 = 1'b0;
        return_25 = 1'b0;
        step(2);
    endtask

    initial begin
        int dc, n;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step();
        chk("reset_ready", int'(coin_ready), 1);
        chk("reset_level25", int'(level_25), 10);

        insert(2, dc, n);
        chk("q25_detect_cycles", dc, 8);
        chk("q25_busy_cycles", n, 48);
        chk("q25_level", int'(level_25), 11);

        coin_valid = 1'b1;
        coin_type = 2'd3;
        step();
        coin_valid = 1'b0;
        chk("slug_reject", int'(coin_reject), 1);
        chk("slug_ready", int'(coin_ready), 1);
        step();
        chk("slug_reject_once", int'(coin_reject), 0);

        ret_pulse(1, 4);
        ret_pulse(1, 2);
        chk("ret10_glitch", int'(level_10), 9);

        for (int k = 0; k < 10; k++) ret_pulse(0, 4);
        chk("drain_level5", int'(level_5), 0);
        chk("drain_empty5", int'(empty_5), 1);
        chk("drain_noerr", int'(err_underflow), 0);
        ret_pulse(0, 5);
        chk("underflow_err", int'(err_underflow), 1);
        chk("underflow_level", int'(level_5), 0);
        refill = 1'b1;
        step();
        refill = 1'b0;
        chk("refill_level5", int'(level_5), 10);
        chk("refill_empty5", int'(empty_5), 0);
        chk("refill_err_kept", int'(err_underflow), 1);

        for (int k = 0; k < 53; k++) insert(0, dc, n);
        chk("fill_level5", int'(level_5), 63);
        insert(0, dc, n);
        chk("full_detect", dc, 8);
        chk("full_level5", int'(level_5), 63);
        ret_pulse(0, 4);
        chk("full_minus1", int'(level_5), 62);
        coin_valid = 1'b1;
        coin_type = 2'd0;
        step();
        coin_valid = 1'b0;
        step(2);
        return_5 = 1'b1;
        step(5);
        return_5 = 1'b0;
        step();
        chk("inc_dec_same", int'(level_5), 62);
        chk("inc_dec_gap", int'(detect_5), 0);
        n = 0;
        while (!coin_ready && n < 200) begin
            step();
            n++;
        end
        chk("gap_done", int'(coin_ready), 1);

        coin_valid = 1'b1;
        coin_type = 2'd2;
        step();
        coin_valid = 1'b0;
        step(2);
        return_25 = 1'b1;
        step(2);
        reset = 1'b1;
        step();
        chk("rst_mid_detect", int'(detect_25), 0);
        chk("rst_mid_level5", int'(level_5), 10);
        reset = 1'b0;
        step(2);
        return_25 = 1'b0;
        step(2);
        chk("rst_ret_ignored", int'(level_25), 10);

        for (int k = 0; k < 4000; k++) begin
            coin_valid = ($urandom % 4) == 0;
            coin_type = 2'($urandom % 4);
            if ($urandom % 3 == 0) return_5 = ~return_5;
            if ($urandom % 3 == 0) return_10 = ~return_10;
            if ($urandom % 3 == 0) return_25 = ~return_25;
            refill = ($urandom % 300) == 0;
            reset = ($urandom % 1000) == 0;
            step();
        end
        coin_valid = 1'b0;
        refill = 1'b0;
        reset = 1'b0;
        return_5 = 1'b0;
        return_10 = 1'b0;
        return_25 = 1'b0;
        step(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
